pace_scan_loader: RTL and testbench

- Synthesizable, parametrised sequencer that drives the PACE scan configuration interface from a parallel command stream.
- Serialises address and data words to load CMEM/DMEM over the scan port.
- Reads DMEM back serially and compares it against expected values, keeping a mismatch count.
- Runs the execution handshake (scan_start_exec / exec_end) with a post-exec hold and a timeout. Sits between a host or test controller and the PACE array scan pins.

---
 rtl/pace_loader_pkg.sv | 28 ++
 rtl/pace_scan_shifter.sv | 52 +++++
 rtl/pace_scan_loader.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pace_scan_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pace_loader_pkg.sv
// Shared types and helpers for the PACE scan loader.
package pace_loader_pkg;

    // Host command opcodes. The reserved code is accepted and completes as a no-op.
    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_CHECK = 2'd1,
        OP_EXEC  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SH_ADDR,
        S_SH_DATA,
        S_STROBE,
        S_CAPTURE,
        S_COMPARE,
        S_EXEC_WAIT,
        S_EXEC_TAIL
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pace_scan_shifter.sv
// Combined parallel-in/serial-out and serial-in/parallel-out shift register
// with a shift counter. The MSB is the serial output; serial input enters at the LSB.
module pace_scan_shifter #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [W-1:0]  load_val,
    input  logic          shift_en,
    input  logic          ser_in,
    output logic          msb,
    output logic [W-1:0]  next_val,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign next_val = {sreg_q[W-2:0], ser_in};
    assign msb      = sreg_q[W-1];
    assign cnt      = cnt_q;

    // Next-state: a load restarts the bit counter, a shift advances it.
    always_comb begin
        // NOTE: hold values are assigned first so no path leaves a variable unassigned (no latch).
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_en) begin
            sreg_d = load_val;
            cnt_d  = '0;
        end else if (shift_en) begin
            sreg_d = next_val;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // Shift register and counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath flops are reset too (no memories here), so an aborted operation leaves nothing stale.
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking in clocked blocks, blocking only in always_comb.
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pace_scan_loader.sv
// Sequencer that turns parallel LOAD/CHECK/EXEC commands into PACE scan-port
// activity: serial address/data loads, serial read-back compare, and the exec handshake.
module pace_scan_loader
    import pace_loader_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int EXEC_TAIL    = 24,
    parameter int EXEC_TIMEOUT = 1048576,
    parameter int ERR_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              scan_data_or_addr,
    output logic              scan_shift_en,
    output logic              read_write,
    output logic              scan_strobe,
    input  logic              scan_out,
    output logic              scan_start_exec,
    input  logic              exec_end,
    input  logic              clr_err,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic              mismatch_valid,
    output logic [ADDR_W-1:0] mismatch_addr,
    output logic [DATA_W-1:0] mismatch_data,
    output logic              timeout
);

    localparam int SH_W  = max_int(ADDR_W, DATA_W);
    localparam int SH_CW = $clog2(SH_W + 1);
    localparam int CNT_W = $clog2(max_int(EXEC_TIMEOUT, EXEC_TAIL) + 1);

    localparam logic [SH_CW-1:0] ADDR_LAST = SH_CW'(ADDR_W - 1);
    localparam logic [SH_CW-1:0] DATA_LAST = SH_CW'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(EXEC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(EXEC_TAIL - 1);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                exec_end_q, exec_end_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                shift_en_q, shift_en_d;
    logic                strobe_q, strobe_d;
    logic                rw_q, rw_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                mm_valid_q, mm_valid_d;
    logic [ADDR_W-1:0]   mm_addr_q, mm_addr_d;
    logic [DATA_W-1:0]   mm_data_q, mm_data_d;
    logic                timeout_q, timeout_d;

    logic                sh_load, sh_shift, sh_in, sh_msb;
    logic [SH_W-1:0]     sh_load_val, sh_next;
    logic [SH_CW-1:0]    sh_cnt;
    logic                exec_rise;

    // One shifter serves address out, data out and read-back capture in turn.
    pace_scan_shifter #(.W(SH_W), .CW(SH_CW)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (sh_load),
        .load_val (sh_load_val),
        .shift_en (sh_shift),
        .ser_in   (sh_in),
        .msb      (sh_msb),
        .next_val (sh_next),
        .cnt      (sh_cnt)
    );

    assign exec_rise = exec_end & ~exec_end_q;

    // Sequencer next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        exec_end_d  = exec_end;
        shift_en_d  = 1'b0;
        strobe_d    = 1'b0;
        rw_d        = 1'b0;
        start_d     = start_q;
        done_d      = 1'b0;
        mm_valid_d  = 1'b0;
        mm_addr_d   = mm_addr_q;
        mm_data_d   = mm_data_q;
        err_d       = clr_err ? '0 : err_q;
        timeout_d   = clr_err ? 1'b0 : timeout_q;
        sh_load     = 1'b0;
        sh_load_val = '0;
        sh_shift    = 1'b0;
        sh_in       = 1'b0;

        // The mismatch is counted while its pulse is visible, after any clear.
        if (state_q == S_COMPARE && mm_valid_q && err_d != '1) begin
            err_d = err_d + ERR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = op_e'(cmd_op);
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    case (op_e'(cmd_op))
                        OP_LOAD, OP_CHECK: begin
                            state_d     = S_SH_ADDR;
                            shift_en_d  = 1'b1;
                            sh_load     = 1'b1;
                            sh_load_val = SH_W'(cmd_addr) << (SH_W - ADDR_W);
                        end
                        OP_EXEC: begin
                            state_d = S_EXEC_WAIT;
                            start_d = 1'b1;
                            cnt_d   = '0;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            S_SH_ADDR: begin
                if (sh_cnt == ADDR_LAST) begin
                    if (op_q == OP_LOAD) begin
                        state_d     = S_SH_DATA;
                        shift_en_d  = 1'b1;
                        sh_load     = 1'b1;
                        sh_load_val = SH_W'(data_q) << (SH_W - DATA_W);
                    end else begin
                        state_d  = S_STROBE;
                        strobe_d = 1'b1;
                    end
                end else begin
                    shift_en_d = 1'b1;
                    sh_shift   = 1'b1;
                end
            end
            S_SH_DATA: begin
                if (sh_cnt == DATA_LAST) begin
                    state_d  = S_STROBE;
                    strobe_d = 1'b1;
                    rw_d     = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    shift_en_d = 1'b1;
                    sh_shift   = 1'b1;
                end
            end
            S_STROBE: begin
                if (op_q == OP_LOAD) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CAPTURE;
                    sh_load = 1'b1;
                end
            end
            S_CAPTURE: begin
                sh_shift = 1'b1;
                sh_in    = scan_out;
                if (sh_cnt == DATA_LAST) begin
                    state_d = S_COMPARE;
                    done_d  = 1'b1;
                    if (sh_next[DATA_W-1:0] != data_q) begin
                        mm_valid_d = 1'b1;
                        mm_addr_d  = addr_q;
                        mm_data_d  = sh_next[DATA_W-1:0];
                    end
                end
            end
            S_COMPARE: state_d = S_IDLE;
            S_EXEC_WAIT: begin
                if (exec_rise) begin
                    state_d = S_EXEC_TAIL;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d   = S_IDLE;
                    start_d   = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    state_d = S_IDLE;
                    start_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, command latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            exec_end_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            shift_en_q  <= 1'b0;
            strobe_q    <= 1'b0;
            rw_q        <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            mm_valid_q  <= 1'b0;
            mm_addr_q   <= '0;
            mm_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            exec_end_q  <= exec_end_d;
            cmd_ready_q <= cmd_ready_d;
            shift_en_q  <= shift_en_d;
            strobe_q    <= strobe_d;
            rw_q        <= rw_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mm_valid_q  <= mm_valid_d;
            mm_addr_q   <= mm_addr_d;
            mm_data_q   <= mm_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign scan_shift_en     = shift_en_q;
    assign scan_data_or_addr = shift_en_q & sh_msb;
    assign scan_strobe       = strobe_q;
    assign read_write        = rw_q;
    assign scan_start_exec   = start_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err_count         = err_q;
    assign mismatch_valid    = mm_valid_q;
    assign mismatch_addr     = mm_addr_q;
    assign mismatch_data     = mm_data_q;
    assign timeout           = timeout_q;

endmodule

// File: tb/tb_pace_scan_loader.sv
// Directed bench for pace_scan_loader with a small serial read-back array model.
module tb_pace_scan_loader;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int ERR_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              scan_data_or_addr;
    logic              scan_shift_en;
    logic              read_write;
    logic              scan_strobe;
    logic              scan_out;
    logic              scan_start_exec;
    logic              exec_end;
    logic              clr_err;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_count;
    logic              mismatch_valid;
    logic [ADDR_W-1:0] mismatch_addr;
    logic [DATA_W-1:0] mismatch_data;
    logic              timeout;

    int                n_vec = 0;
    int                n_bad = 0;
    int                gate_viol = 0;
    logic [DATA_W-1:0] model_rd = '0;

    pace_scan_loader #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .EXEC_TAIL    (24),
        .EXEC_TIMEOUT (128),
        .ERR_W        (ERR_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_addr          (cmd_addr),
        .cmd_data          (cmd_data),
        .scan_data_or_addr (scan_data_or_addr),
        .scan_shift_en     (scan_shift_en),
        .read_write        (read_write),
        .scan_strobe       (scan_strobe),
        .scan_out          (scan_out),
        .scan_start_exec   (scan_start_exec),
        .exec_end          (exec_end),
        .clr_err           (clr_err),
        .busy              (busy),
        .done              (done),
        .err_count         (err_count),
        .mismatch_valid    (mismatch_valid),
        .mismatch_addr     (mismatch_addr),
        .mismatch_data     (mismatch_data),
        .timeout           (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {20'd0, cmd_ready, scan_data_or_addr, scan_shift_en, read_write, scan_strobe,
                scan_start_exec, busy, done, err_count, mismatch_valid, mismatch_addr,
                mismatch_data, timeout};
    endfunction

    // Serial data and read_write must be quiet outside their qualifying strobes.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (scan_shift_en !== 1'b1 && scan_data_or_addr !== 1'b0) gate_viol++;
            if (scan_strobe !== 1'b1 && read_write !== 1'b0) gate_viol++;
        end
    end

    // Array model: after a read strobe, return model_rd MSB first, one bit per cycle.
    initial begin : array_model
        scan_out = 1'b0;
        forever begin
            @(negedge clk);
            if (scan_strobe === 1'b1 && read_write === 1'b0) begin
                for (int b = DATA_W - 1; b >= 0; b--) begin
                    @(negedge clk);
                    scan_out = model_rd[b];
                end
                @(negedge clk);
                scan_out = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Waits (bounded) for cmd_ready, presents one command, returns at the negedge of T+1.
    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
    endtask

    task automatic run_load(input string tag, input logic [15:0] a, input logic [15:0] d);
        logic [31:0] bits = '0;
        int sh_cnt = 0;
        int stb_cnt = 0;
        send(2'd0, a, d);
        for (int k = 1; k <= 32; k++) begin
            if (scan_shift_en === 1'b1) begin
                sh_cnt++;
                bits = {bits[30:0], scan_data_or_addr};
            end
            if (scan_strobe === 1'b1) stb_cnt++;
            @(negedge clk);
        end
        check({tag, "_serial"}, bits, {a, d});
        check({tag, "_shift_cycles"}, sh_cnt, 32);
        check({tag, "_early_strobe"}, stb_cnt, 0);
        check({tag, "_t33_stb_rw_done_rdy"}, {scan_strobe, read_write, done, cmd_ready}, 4'b1110);
        @(negedge clk);
        check({tag, "_t34_stb_done_rdy_busy"}, {scan_strobe, done, cmd_ready, busy}, 4'b0010);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] exp_d,
                             input logic [15:0] rd, input bit do_clr, input logic [1:0] exp_err);
        logic [15:0] abits = '0;
        logic [15:0] mm_a = '0;
        logic [15:0] mm_d = '0;
        int sh_cnt = 0;
        int stb_cyc = 0;
        int done_cyc = 0;
        int mm_cnt = 0;
        int mm_cyc = 0;
        bit exp_mm;
        exp_mm   = (rd != exp_d);
        model_rd = rd;
        send(2'd1, a, exp_d);
        for (int k = 1; k <= 40; k++) begin
            if (scan_shift_en === 1'b1) begin
                sh_cnt++;
                abits = {abits[14:0], scan_data_or_addr};
            end
            if (scan_strobe === 1'b1 && read_write === 1'b0 && stb_cyc == 0) stb_cyc = k;
            if (done === 1'b1 && done_cyc == 0) done_cyc = k;
            if (mismatch_valid === 1'b1) begin
                mm_cnt++;
                mm_cyc = k;
                mm_a   = mismatch_addr;
                mm_d   = mismatch_data;
            end
            clr_err = do_clr && (mismatch_valid === 1'b1);
            @(negedge clk);
        end
        clr_err = 1'b0;
        check({tag, "_addr_serial"}, abits, a);
        check({tag, "_shift_cycles"}, sh_cnt, 16);
        check({tag, "_read_strobe_cycle"}, stb_cyc, 17);
        check({tag, "_done_cycle"}, done_cyc, 34);
        check({tag, "_mismatch_pulses"}, mm_cnt, exp_mm ? 1 : 0);
        if (exp_mm) begin
            check({tag, "_mismatch_cycle"}, mm_cyc, 34);
            check({tag, "_mismatch_addr"}, mm_a, a);
            check({tag, "_mismatch_data"}, mm_d, rd);
        end
        check({tag, "_err_count"}, err_count, exp_err);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin : main
        int first_low;
        int done_cyc;
        int evt;
        logic start_at1;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = '0;
        cmd_data  = '0;
        exec_end  = 1'b0;
        clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", out_vec(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready_busy", {cmd_ready, busy}, 2'b10);

        run_load("load_0003_a5c3", 16'h0003, 16'hA5C3);
        run_load("load_8001_7ffe", 16'h8001, 16'h7FFE);

        run_check("chk_match",     16'h0010, 16'h1234, 16'h1234, 1'b0, 2'd0);
        run_check("chk_lsb_diff",  16'h0010, 16'h1234, 16'h1235, 1'b0, 2'd1);
        run_check("chk_clr_same",  16'h0010, 16'h1234, 16'h1235, 1'b1, 2'd1);
        run_check("chk_msb_diff",  16'hABCD, 16'h0000, 16'h8000, 1'b0, 2'd2);
        run_check("chk_to_max",    16'hFFFF, 16'hFFFF, 16'h7FFF, 1'b0, 2'd3);
        run_check("chk_saturate",  16'h0001, 16'h5A5A, 16'hA5A5, 1'b0, 2'd3);

        // Reserved op: done one cycle after accept, nothing else moves.
        send(2'd3, 16'h1111, 16'h2222);
        check("rsvd_done_t1", done, 1);
        check("rsvd_quiet_t1", {scan_shift_en, scan_strobe, busy, scan_start_exec}, 4'b0000);
        @(negedge clk);
        check("rsvd_done_t2", done, 0);

        // EXEC with exec_end rising in cycle T+100.
        send(2'd2, 16'h0000, 16'h0000);
        start_at1 = scan_start_exec;
        first_low = 0;
        done_cyc  = 0;
        for (int k = 1; k <= 140; k++) begin
            if (scan_start_exec !== 1'b1 && first_low == 0) first_low = k;
            if (done === 1'b1 && done_cyc == 0) done_cyc = k;
            if (k == 100) exec_end = 1'b1;
            @(negedge clk);
        end
        exec_end = 1'b0;
        check("exec_start_t1", start_at1, 1);
        check("exec_start_first_low", first_low, 125);
        check("exec_done_cycle", done_cyc, 125);
        check("exec_no_timeout", timeout, 0);

        // EXEC with exec_end already high at accept: only the timeout can end it.
        exec_end = 1'b1;
        repeat (3) @(negedge clk);
        send(2'd2, 16'h0000, 16'h0000);
        first_low = 0;
        done_cyc  = 0;
        for (int k = 1; k <= 140; k++) begin
            if (scan_start_exec !== 1'b1 && first_low == 0) first_low = k;
            if (done === 1'b1 && done_cyc == 0) done_cyc = k;
            @(negedge clk);
        end
        check("tmo_start_first_low", first_low, 129);
        check("tmo_done_cycle", done_cyc, 129);
        check("tmo_flags", {timeout, busy, scan_start_exec}, 3'b100);
        exec_end = 1'b0;

        // clr_err in idle clears both the saturated count and the sticky timeout.
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err_idle", {err_count, timeout}, 3'b000);

        // Reset in cycle 10 of a LOAD.
        send(2'd0, 16'hF0F0, 16'h0F0F);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midload_reset_zero", out_vec(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        evt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (scan_strobe === 1'b1 || done === 1'b1 || scan_shift_en === 1'b1) evt++;
        end
        check("midload_no_activity", evt, 0);
        run_load("load_after_reset", 16'h00FF, 16'hC001);

        check("gating_violations", gate_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
